// File: rtl/ssd_pkg.sv
// Shared seven-segment constants ({g,f,e,d,c,b,a}, active-high) and pin polarity helper.
package ssd_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Maps an active-high {dp, seg} pattern onto the board pin polarity.
  function automatic logic [7:0] apply_pol(input logic [7:0] pins, input logic active_low);
    return active_low ? ~pins : pins;
  endfunction

endpackage

// File: rtl/ssd_hex_font.sv
// Combinational hex nibble to active-high segment pattern (b and d lowercase).
module ssd_hex_font
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment driver: shadow/active frame buffering, PWM brightness,
// leading-zero blanking; pins are registered one cycle after the scan state.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SUB_DIV    = 3125,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  input  logic [4:0]            duty,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int PS_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam bit POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_IDLE = POL_LOW ? '1 : '0;

  logic [PS_W-1:0]       presc_q, presc_d;
  logic [3:0]            phase_q, phase_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [4*N_DIGITS-1:0] shadow_val_q, shadow_val_d, active_val_q, active_val_d;
  logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic                  pending_q, pending_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  sub_tick, slot_end, frame_wrap;
  logic [3:0]            cur_nibble;
  logic [6:0]            font_seg;

  ssd_hex_font u_font (
    .nibble (cur_nibble),
    .seg    (font_seg)
  );

  always_comb begin
    presc_d  = presc_q;
    phase_d  = phase_q;
    index_d  = index_q;
    sub_tick   = enable && (presc_q == PS_W'(SUB_DIV - 1));
    slot_end   = sub_tick && (phase_q == 4'hF);
    frame_wrap = slot_end && (index_q == IDX_W'(N_DIGITS - 1));
    if (enable) presc_d = sub_tick ? '0 : presc_q + 1'b1;
    if (sub_tick) phase_d = phase_q + 1'b1;
    if (slot_end) index_d = frame_wrap ? '0 : index_q + 1'b1;
    frame_tick_d = frame_wrap;
  end

  // A load coinciding with the frame boundary lands in shadow and waits for the next frame.
  always_comb begin
    shadow_val_d = load ? value : shadow_val_q;
    shadow_dp_d  = load ? dp_in : shadow_dp_q;
    pending_d    = load | (pending_q & ~frame_wrap);
    active_val_d = (frame_wrap && pending_q) ? shadow_val_q : active_val_q;
    active_dp_d  = (frame_wrap && pending_q) ? shadow_dp_q : active_dp_q;
  end

  logic [4:0]          duty_eff;
  logic                lit, blank, dp_bit, zero_run;
  logic [N_DIGITS-1:0] upper_zero, an_raw;
  logic [6:0]          seg_raw;

  always_comb begin
    duty_eff   = (duty > 5'd16) ? 5'd16 : duty;
    lit        = enable && ({1'b0, phase_q} < duty_eff);
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (active_val_q[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end
    cur_nibble = 4'h0;
    dp_bit     = 1'b0;
    blank      = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (index_q == IDX_W'(i)) begin
        cur_nibble = active_val_q[4*i +: 4];
        dp_bit     = active_dp_q[i];
        blank      = blank_lz && (i != 0) && upper_zero[i];
      end
    end
    an_raw = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (index_q == IDX_W'(i) && lit && (!blank || dp_bit)) an_raw[i] = 1'b1;
    end
    seg_raw       = (lit && !blank) ? font_seg : SEG_OFF;
    an_d          = an_raw ^ AN_IDLE;
    {dp_d, seg_d} = apply_pol({lit && dp_bit, seg_raw}, POL_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      phase_q       <= '0;
      index_q       <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      active_val_q  <= '0;
      active_dp_q   <= '0;
      pending_q     <= 1'b0;
      frame_tick_q  <= 1'b0;
      an_q          <= AN_IDLE;
      {dp_q, seg_q} <= apply_pol({1'b0, SEG_OFF}, POL_LOW);
    end else begin
      presc_q       <= presc_d;
      phase_q       <= phase_d;
      index_q       <= index_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      active_val_q  <= active_val_d;
      active_dp_q   <= active_dp_d;
      pending_q     <= pending_d;
      frame_tick_q  <= frame_tick_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Frame-level scoreboard bench for ssd_scan_driver (4 digits, SUB_DIV=2, active-low pins).
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst, enable, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [4:0]  duty;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] sb_q[$];

  always #5 clk = ~clk;

  ssd_scan_driver #(.N_DIGITS(4), .SUB_DIV(2), .ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .duty       (duty),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font_al(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected {an, seg, dp} while a digit slot is being scanned.
  function automatic logic [11:0] exp_pins(input logic [15:0] v, input logic [3:0] dpv,
                                           input logic blz, input logic [4:0] dty,
                                           input int digit, input int phase);
    int          d;
    logic        lit, blank, dpb;
    logic [15:0] upper;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    d     = (dty > 16) ? 16 : int'(dty);
    lit   = phase < d;
    upper = v >> (4 * digit);
    blank = blz && (digit > 0) && (upper == 16'h0);
    dpb   = dpv[digit];
    an_e  = 4'hF;
    if (lit && (!blank || dpb)) an_e[digit] = 1'b0;
    seg_e = (lit && !blank) ? font_al(upper[3:0]) : 7'h7F;
    return {an_e, seg_e, ~(lit && dpb)};
  endfunction

  // Called at the sample point of the cycle where the scan is at index 0, phase 0, prescaler 0.
  // Returns at the sample where frame_tick is expected, i.e. the start of the next frame.
  task automatic check_frame(input logic [15:0] v, input logic [3:0] dpv, input logic blz,
                             input logic [4:0] dty,
                             input int ld_t1, input logic [15:0] ld_v1, input logic [3:0] ld_d1,
                             input int ld_t2, input logic [15:0] ld_v2, input logic [3:0] ld_d2,
                             input int dis_t, input int dis_len);
    int         s, t;
    bit         done;
    logic       en;
    logic [12:0] e;
    s = 0; t = 0; done = 0;
    blank_lz = blz;
    duty     = dty;
    while (!done && t < 1000) begin
      if (t > 0) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'd0, 32'd1);
          done = 1;
        end else begin
          e = sb_q.pop_front();
          check_eq($sformatf("frame v=%h t=%0d", v, t), {frame_tick, an, seg, dp}, e);
          if (e[12]) done = 1;
        end
      end
      if (!done) begin
        en     = !(dis_len > 0 && t >= dis_t && t < dis_t + dis_len);
        enable = en;
        load   = 1'b0;
        if (t == ld_t1) begin load = 1'b1; value = ld_v1; dp_in = ld_d1; end
        if (t == ld_t2) begin load = 1'b1; value = ld_v2; dp_in = ld_d2; end
        if (en) begin
          sb_q.push_back({s == 127, exp_pins(v, dpv, blz, dty, s / 32, (s % 32) / 2)});
          s++;
        end else begin
          sb_q.push_back({1'b0, 4'hF, 7'h7F, 1'b1});
        end
        t++;
      end
    end
    if (!done) check_eq("frame_timeout", 32'd0, 32'd1);
    load = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    blank_lz = 1'b0; duty = 5'd16;
    repeat (3) @(negedge clk);
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_dp", dp, 1'b1);
    check_eq("rst_ft", frame_tick, 1'b0);
    rst = 1'b0;

    // Reset frame shows 0000 while 1234 waits in shadow.
    check_frame(16'h0000, 4'h0, 1'b0, 5'd16, 0, 16'h1234, 4'h0, -1, 16'h0, 4'h0, 0, 0);
    check_frame(16'h1234, 4'h0, 1'b0, 5'd16, 10, 16'h0050, 4'b0001, -1, 16'h0, 4'h0, 0, 0);
    // Leading-zero blanking on, then off.
    check_frame(16'h0050, 4'b0001, 1'b1, 5'd16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 0, 0);
    check_frame(16'h0050, 4'b0001, 1'b0, 5'd16, 5, 16'h0050, 4'b0100, -1, 16'h0, 4'h0, 0, 0);
    // Blanked digit with dp set; half, zero and over-range duty.
    check_frame(16'h0050, 4'b0100, 1'b1, 5'd8, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 0, 0);
    check_frame(16'h0050, 4'b0100, 1'b1, 5'd0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 0, 0);
    check_frame(16'h0050, 4'b0100, 1'b1, 5'd20, 40, 16'hABCD, 4'h0, 100, 16'hEF01, 4'h0, 0, 0);
    // Last mid-frame load wins; a load on the boundary cycle waits one more frame.
    check_frame(16'hEF01, 4'h0, 1'b0, 5'd16, 50, 16'h1111, 4'b1010, 127, 16'h2468, 4'b0101, 0, 0);
    check_frame(16'h1111, 4'b1010, 1'b0, 5'd16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 50, 100);
    check_frame(16'h2468, 4'b0101, 1'b0, 5'd16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 0, 0);

    // Reset in the middle of digit 2.
    repeat (80) @(negedge clk);
    check_eq("pre_rst_an", an, 4'b1011);
    check_eq("pre_rst_seg", seg, 7'h19);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_an", an, 4'hF);
    check_eq("mid_rst_seg", seg, 7'h7F);
    check_eq("mid_rst_dp", dp, 1'b1);
    check_eq("mid_rst_ft", frame_tick, 1'b0);
    rst = 1'b0;
    check_frame(16'h0000, 4'h0, 1'b0, 5'd16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
